rob_param: RTL and testbench
============================

Name: rob_param

Overview:
- Parametrised reorder buffer for the execution pipeline; successor to the fixed 16-entry ROB sizing.
- Allocates one entry per cycle from issue and captures results from the CDB out of order.
- Retires in order, one entry per cycle, to the commit stage.
- Serves two operand-lookup ports for the issue stage, with CDB bypass, and supports a full pipeline flush.

Parameters:
- DEPTH, 16, number of entries; any value >= 2, not restricted to powers of 2.
- XLEN, 64, result and PC width.
- REG_IDX_LEN, 5, destination register index width.
- TAG_LEN, $clog2(DEPTH), entry tag width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  discard all entries
- issue_valid_i  in  1  issue requests allocation
- issue_ready_o  out  1  ROB can accept
- issue_pc_i  in  XLEN  instruction PC
- issue_rd_idx_i  in  REG_IDX_LEN  destination register
- issue_rd_fp_i  in  1  destination is FP register file
- issue_tag_o  out  TAG_LEN  tag of entry allocated on this handshake (= tail)
- cdb_valid_i  in  1  result broadcast
- cdb_tag_i  in  TAG_LEN  producing entry
- cdb_data_i  in  XLEN  result value
- cdb_except_i  in  1  instruction raised exception
- rs1_tag_i, rs2_tag_i  in  TAG_LEN  operand lookup tags
- rs1_ready_o, rs2_ready_o  out  1  looked-up entry has its result
- rs1_value_o, rs2_value_o  out  XLEN  looked-up result
- commit_valid_o  out  1  head entry complete
- commit_ready_i  in  1  commit stage accepts
- commit_tag_o  out  TAG_LEN  head tag
- commit_pc_o  out  XLEN  head PC
- commit_rd_idx_o  out  REG_IDX_LEN  head destination
- commit_rd_fp_o  out  1  head FP flag
- commit_value_o  out  XLEN  head result
- commit_except_o  out  1  head exception flag

Behaviour:
- State:
  - per entry: valid, done, except, pc, rd_idx, rd_fp, value;
  - head and tail pointers in 0..DEPTH-1;
  - count in 0..DEPTH, width $clog2(DEPTH+1).
- Reset (async, rst_n_i low): all valid/done/except bits cleared; head = tail = count = 0.
  - Resulting outputs: issue_ready_o = 1, commit_valid_o = 0, issue_tag_o = 0, rs*_ready_o = 0.
  - Payload registers need not be reset.
- Allocation: issue_ready_o = (count != DEPTH), independent of commit in the same cycle.
  - On issue_valid_i & issue_ready_o: entry[tail] is written with valid = 1, done = 0, except = 0 and the payload.
  - tail increments, wrapping DEPTH-1 -> 0.
- CDB write: on cdb_valid_i, if entry[cdb_tag_i].valid, set done = 1, value = cdb_data_i, except = cdb_except_i.
  - Writes to invalid entries are ignored.
  - A second write to a done entry overwrites it.
- Commit:
  - commit_valid_o = entry[head].valid & entry[head].done, from registered state only.
  - A CDB write to head is therefore visible one cycle later.
  - commit_* outputs are combinational from entry[head].
  - On commit_valid_o & commit_ready_i: clear entry[head].valid and done; head increments with wrap.
  - An exception is only reported on commit_except_o. The consumer decides whether to assert flush_i.
- Count update: count +1 on allocate only, -1 on commit only, unchanged when both or neither occur.
- Operand lookup:
  - rsN_ready_o = entry[tag].done, or (cdb_valid_i & cdb_tag_i == tag & entry[tag].valid).
  - rsN_value_o takes cdb_data_i on a bypass hit, otherwise entry[tag].value.
  - Purely combinational; zero latency.
- Flush: synchronous, highest priority. In that cycle all valid/done bits clear and head = tail = count = 0.
  - Allocation, CDB write and commit in the same cycle are discarded.
  - issue_ready_o stays 1 during flush, but the handshake has no effect.
- Full: with count = DEPTH, an allocate is blocked even while a commit fires; it is accepted the next cycle.
- Empty: commit_valid_o = 0. A result written the same cycle as allocation is impossible, since the tag is not yet known downstream.

Test Plan:
- Reset, then allocate 3 entries (PC 0x100, 0x104, 0x108) -> issue_tag_o = 0, 1, 2; commit_valid_o stays 0 until a CDB write.
- CDB writes tag 2 (0xAA), then tag 0 (0x55), then tag 1 (0x77) -> commits occur in order 0, 1, 2 with values 0x55, 0x77, 0xAA; each commit_valid_o rises one cycle after the head's CDB write.
- DEPTH = 5: fill 5 entries -> issue_ready_o = 0; allocate plus commit in the same cycle -> no allocation, count = 4. Refill -> tail wraps and the next tag is 0.
- Lookup rs1_tag_i = 3 while the CDB broadcasts tag 3 / 0xDEAD -> rs1_ready_o = 1, rs1_value_o = 0xDEAD in the same cycle; the next cycle shows the same from storage.
- CDB with except = 1 on head, commit_ready_i = 1, flush_i asserted the next cycle together with issue_valid_i -> commit_except_o = 1 on retire; after the flush count = 0, commit_valid_o = 0, and the next issue_tag_o = 0.
- Assert rst_n_i low mid-operation with 4 entries live -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rob_param.sv
// Parametrised reorder buffer: one allocate and one in-order retire per cycle, out-of-order CDB capture.
// Operand lookup and commit outputs are zero-latency; issue stalls only when count reaches DEPTH.
module rob_param #(
  parameter int DEPTH       = 16,
  parameter int XLEN        = 64,
  parameter int REG_IDX_LEN = 5,
  parameter int TAG_LEN     = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic [XLEN-1:0]        issue_pc_i,
  input  logic [REG_IDX_LEN-1:0] issue_rd_idx_i,
  input  logic                   issue_rd_fp_i,
  output logic [TAG_LEN-1:0]     issue_tag_o,
  input  logic                   cdb_valid_i,
  input  logic [TAG_LEN-1:0]     cdb_tag_i,
  input  logic [XLEN-1:0]        cdb_data_i,
  input  logic                   cdb_except_i,
  input  logic [TAG_LEN-1:0]     rs1_tag_i,
  input  logic [TAG_LEN-1:0]     rs2_tag_i,
  output logic                   rs1_ready_o,
  output logic                   rs2_ready_o,
  output logic [XLEN-1:0]        rs1_value_o,
  output logic [XLEN-1:0]        rs2_value_o,
  output logic                   commit_valid_o,
  input  logic                   commit_ready_i,
  output logic [TAG_LEN-1:0]     commit_tag_o,
  output logic [XLEN-1:0]        commit_pc_o,
  output logic [REG_IDX_LEN-1:0] commit_rd_idx_o,
  output logic                   commit_rd_fp_o,
  output logic [XLEN-1:0]        commit_value_o,
  output logic                   commit_except_o
);

  localparam int CNT_LEN = $clog2(DEPTH + 1);
  localparam int PAD_N   = 1 << TAG_LEN;
  localparam logic [TAG_LEN-1:0] LAST = TAG_LEN'(DEPTH - 1);

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [REG_IDX_LEN-1:0] rd_idx;
    logic                   rd_fp;
  } payload_t;

  logic [DEPTH-1:0]   valid_q, valid_d, done_q, done_d, except_q, except_d;
  logic [TAG_LEN-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_LEN-1:0] count_q, count_d;
  payload_t           payload_q [DEPTH];
  logic [XLEN-1:0]    value_q   [DEPTH];

  // Flag vectors widened to the full tag space so any tag, even past DEPTH-1, reads as 0.
  logic [PAD_N-1:0] valid_pad, done_pad, except_pad;
  logic             alloc, commit_fire, cdb_wr, rs1_hit, rs2_hit;

  function automatic logic [TAG_LEN-1:0] next_ptr(input logic [TAG_LEN-1:0] p);
    return (p == LAST) ? '0 : p + TAG_LEN'(1);
  endfunction

  assign valid_pad  = PAD_N'(valid_q);
  assign done_pad   = PAD_N'(done_q);
  assign except_pad = PAD_N'(except_q);

  assign issue_ready_o  = (count_q != CNT_LEN'(DEPTH));
  assign issue_tag_o    = tail_q;
  assign commit_valid_o = valid_pad[head_q] & done_pad[head_q];

  assign alloc       = issue_valid_i & issue_ready_o & ~flush_i;
  assign commit_fire = commit_valid_o & commit_ready_i & ~flush_i;
  assign cdb_wr      = cdb_valid_i & valid_pad[cdb_tag_i] & ~flush_i;

  always_comb begin
    valid_d  = valid_q;
    done_d   = done_q;
    except_d = except_q;
    head_d   = commit_fire ? next_ptr(head_q) : head_q;
    tail_d   = alloc ? next_ptr(tail_q) : tail_q;
    count_d  = count_q;
    if (alloc && !commit_fire)      count_d = count_q + CNT_LEN'(1);
    else if (!alloc && commit_fire) count_d = count_q - CNT_LEN'(1);
    // Ordering matters: retire clears a head that the CDB may rewrite in the same cycle.
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_wr && cdb_tag_i == TAG_LEN'(i)) begin
        done_d[i]   = 1'b1;
        except_d[i] = cdb_except_i;
      end
      if (commit_fire && head_q == TAG_LEN'(i)) begin
        valid_d[i] = 1'b0;
        done_d[i]  = 1'b0;
      end
      if (alloc && tail_q == TAG_LEN'(i)) begin
        valid_d[i]  = 1'b1;
        done_d[i]   = 1'b0;
        except_d[i] = 1'b0;
      end
    end
    if (flush_i) begin
      valid_d  = '0;
      done_d   = '0;
      except_d = '0;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q  <= '0;
      done_q   <= '0;
      except_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      done_q   <= done_d;
      except_q <= except_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc && tail_q == TAG_LEN'(i)) begin
        payload_q[i] <= '{pc: issue_pc_i, rd_idx: issue_rd_idx_i, rd_fp: issue_rd_fp_i};
      end
      if (cdb_wr && cdb_tag_i == TAG_LEN'(i)) begin
        value_q[i] <= cdb_data_i;
      end
    end
  end

  assign rs1_hit     = cdb_valid_i & (cdb_tag_i == rs1_tag_i) & valid_pad[rs1_tag_i];
  assign rs2_hit     = cdb_valid_i & (cdb_tag_i == rs2_tag_i) & valid_pad[rs2_tag_i];
  assign rs1_ready_o = done_pad[rs1_tag_i] | rs1_hit;
  assign rs2_ready_o = done_pad[rs2_tag_i] | rs2_hit;
  assign rs1_value_o = rs1_hit ? cdb_data_i : value_q[rs1_tag_i];
  assign rs2_value_o = rs2_hit ? cdb_data_i : value_q[rs2_tag_i];

  assign commit_tag_o    = head_q;
  assign commit_pc_o     = payload_q[head_q].pc;
  assign commit_rd_idx_o = payload_q[head_q].rd_idx;
  assign commit_rd_fp_o  = payload_q[head_q].rd_fp;
  assign commit_value_o  = value_q[head_q];
  assign commit_except_o = except_pad[head_q];

endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param at DEPTH=5; a negedge monitor checks every retire against a scoreboard.
module tb_rob_param;
  localparam int DEPTH = 5;
  localparam int XLEN  = 64;
  localparam int RL    = 5;
  localparam int TL    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic [XLEN-1:0] issue_pc = '0;
  logic [RL-1:0] issue_rd = '0;
  logic          issue_fp = 1'b0;
  logic [TL-1:0] issue_tag;
  logic          cdb_valid = 1'b0;
  logic [TL-1:0] cdb_tag = '0;
  logic [XLEN-1:0] cdb_data = '0;
  logic          cdb_except = 1'b0;
  logic [TL-1:0] rs1_tag = '0, rs2_tag = '0;
  logic          rs1_ready, rs2_ready;
  logic [XLEN-1:0] rs1_value, rs2_value;
  logic          commit_valid;
  logic          commit_ready = 1'b0;
  logic [TL-1:0] commit_tag;
  logic [XLEN-1:0] commit_pc, commit_value;
  logic [RL-1:0] commit_rd;
  logic          commit_fp, commit_except;

  rob_param #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_IDX_LEN(RL)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_pc_i(issue_pc),
    .issue_rd_idx_i(issue_rd), .issue_rd_fp_i(issue_fp), .issue_tag_o(issue_tag),
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data), .cdb_except_i(cdb_except),
    .rs1_tag_i(rs1_tag), .rs2_tag_i(rs2_tag), .rs1_ready_o(rs1_ready), .rs2_ready_o(rs2_ready),
    .rs1_value_o(rs1_value), .rs2_value_o(rs2_value),
    .commit_valid_o(commit_valid), .commit_ready_i(commit_ready), .commit_tag_o(commit_tag),
    .commit_pc_o(commit_pc), .commit_rd_idx_o(commit_rd), .commit_rd_fp_o(commit_fp),
    .commit_value_o(commit_value), .commit_except_o(commit_except)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TL-1:0]   tag;
    logic [XLEN-1:0] pc;
    logic [RL-1:0]   rd;
    logic            fp;
    logic [XLEN-1:0] val;
    logic            exc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [XLEN-1:0] pc, input logic [RL-1:0] rd, input logic fp);
    issue_valid = 1'b1;
    issue_pc    = pc;
    issue_rd    = rd;
    issue_fp    = fp;
  endtask

  task automatic drive_cdb(input logic [TL-1:0] tag, input logic [XLEN-1:0] data, input logic exc);
    cdb_valid  = 1'b1;
    cdb_tag    = tag;
    cdb_data   = data;
    cdb_except = exc;
  endtask

  // Retire monitor: a handshake seen at negedge fires on the next posedge.
  always @(negedge clk) begin
    if (rst_n && commit_valid && commit_ready && !flush) begin
      if (sb.size() == 0) begin
        chk("unexpected_commit", 64'(commit_tag), 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("commit_tag", 64'(commit_tag), 64'(e.tag));
        chk("commit_pc", commit_pc, e.pc);
        chk("commit_rd", 64'(commit_rd), 64'(e.rd));
        chk("commit_fp", 64'(commit_fp), 64'(e.fp));
        chk("commit_value", commit_value, e.val);
        chk("commit_except", 64'(commit_except), 64'(e.exc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  logic [XLEN-1:0] p1_vals [3] = '{64'h55, 64'h77, 64'hAA};
  logic [TL-1:0]   p3_tags [4] = '{3'd4, 3'd0, 3'd1, 3'd2};
  logic [XLEN-1:0] p3_vals [4] = '{64'h44, 64'h40, 64'h41, 64'h42};
  logic [TL-1:0]   dr_tags [6] = '{3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3};
  logic [XLEN-1:0] dr_vals [6] = '{64'h22, 64'h44, 64'h40, 64'h41, 64'h42, 64'h43};

  initial begin
    #3;
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_issue_tag", 64'(issue_tag), 64'd0);
    chk("rst_rs1_ready", 64'(rs1_ready), 64'd0);
    chk("rst_rs2_ready", 64'(rs2_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Three allocations, results arrive out of order, retire in order.
    commit_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_issue(64'h100 + 64'(4 * i), RL'(i + 1), (i == 1));
      #1;
      chk("alloc_tag", 64'(issue_tag), 64'(i));
      chk("alloc_no_commit", 64'(commit_valid), 64'd0);
      sb.push_back('{TL'(i), 64'h100 + 64'(4 * i), RL'(i + 1), (i == 1), p1_vals[i], 1'b0});
      tick();
    end
    issue_valid = 1'b0;
    drive_cdb(3'd2, 64'hAA, 1'b0);
    rs2_tag = 3'd2;
    #1;
    chk("bypass_rs2_ready", 64'(rs2_ready), 64'd1);
    chk("bypass_rs2_value", rs2_value, 64'hAA);
    chk("head_not_done", 64'(commit_valid), 64'd0);
    tick();
    drive_cdb(3'd0, 64'h55, 1'b0);
    #1;
    chk("commit_registered_only", 64'(commit_valid), 64'd0);
    tick();
    drive_cdb(3'd1, 64'h77, 1'b0);
    #1;
    chk("commit0_valid", 64'(commit_valid), 64'd1);
    chk("commit0_tag", 64'(commit_tag), 64'd0);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("commit1_valid", 64'(commit_valid), 64'd1);
    chk("commit1_tag", 64'(commit_tag), 64'd1);
    tick();
    chk("commit2_tag", 64'(commit_tag), 64'd2);
    tick();
    chk("drained_commit_valid", 64'(commit_valid), 64'd0);

    // Lookup with bypass, then from storage; CDB to an invalid entry is ignored.
    commit_ready = 1'b0;
    drive_issue(64'h200, 5'd7, 1'b0);
    #1;
    chk("alloc3_tag", 64'(issue_tag), 64'd3);
    sb.push_back('{3'd3, 64'h200, 5'd7, 1'b0, 64'hDEAD, 1'b0});
    tick();
    issue_valid = 1'b0;
    drive_cdb(3'd4, 64'h99, 1'b0);
    rs2_tag = 3'd4;
    rs1_tag = 3'd3;
    #1;
    chk("cdb_invalid_rs2_ready", 64'(rs2_ready), 64'd0);
    chk("pending_rs1_ready", 64'(rs1_ready), 64'd0);
    tick();
    drive_cdb(3'd3, 64'hDEAD, 1'b0);
    #1;
    chk("rs1_bypass_ready", 64'(rs1_ready), 64'd1);
    chk("rs1_bypass_value", rs1_value, 64'hDEAD);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("rs1_stored_ready", 64'(rs1_ready), 64'd1);
    chk("rs1_stored_value", rs1_value, 64'hDEAD);
    chk("head3_commit_valid", 64'(commit_valid), 64'd1);

    // Fill to DEPTH with tail wrap 4 -> 0; a full ROB blocks allocate even while committing.
    for (int i = 0; i < 4; i++) begin
      drive_issue(64'h300 + 64'(4 * i), RL'(10 + i), 1'b0);
      #1;
      chk("fill_tag", 64'(issue_tag), 64'(p3_tags[i]));
      chk("fill_ready", 64'(issue_ready), 64'd1);
      sb.push_back('{p3_tags[i], 64'h300 + 64'(4 * i), RL'(10 + i), 1'b0, p3_vals[i], 1'b0});
      tick();
    end
    drive_issue(64'h310, 5'd20, 1'b0);
    #1;
    chk("full_not_ready", 64'(issue_ready), 64'd0);
    commit_ready = 1'b1;
    #1;
    chk("full_ready_ignores_commit", 64'(issue_ready), 64'd0);
    tick();
    chk("after_commit_ready", 64'(issue_ready), 64'd1);
    chk("refill_tag", 64'(issue_tag), 64'd3);
    chk("head4_not_done", 64'(commit_valid), 64'd0);
    sb.push_back('{3'd3, 64'h310, 5'd20, 1'b0, 64'h43, 1'b0});
    tick();
    issue_valid = 1'b0;
    #1;
    chk("refilled_full", 64'(issue_ready), 64'd0);

    // Drain; tag 2 is written twice and the second value must win.
    for (int i = 0; i < 6; i++) begin
      drive_cdb(dr_tags[i], dr_vals[i], 1'b0);
      tick();
    end
    cdb_valid = 1'b0;
    tick();
    tick();
    chk("drain_commit_valid", 64'(commit_valid), 64'd0);
    chk("drain_issue_ready", 64'(issue_ready), 64'd1);

    // Exception on head retires, then flush together with an issue request.
    drive_issue(64'h400, 5'd1, 1'b0);
    #1;
    chk("exc_alloc_tag", 64'(issue_tag), 64'd4);
    sb.push_back('{3'd4, 64'h400, 5'd1, 1'b0, 64'hE0, 1'b1});
    tick();
    drive_issue(64'h404, 5'd2, 1'b0);
    #1;
    chk("exc_alloc2_tag", 64'(issue_tag), 64'd0);
    tick();
    issue_valid = 1'b0;
    drive_cdb(3'd4, 64'hE0, 1'b1);
    #1;
    chk("exc_not_yet_valid", 64'(commit_valid), 64'd0);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("exc_commit_valid", 64'(commit_valid), 64'd1);
    chk("exc_commit_except", 64'(commit_except), 64'd1);
    tick();
    flush = 1'b1;
    drive_issue(64'h500, 5'd3, 1'b0);
    drive_cdb(3'd0, 64'h77, 1'b0);
    #1;
    chk("flush_issue_ready", 64'(issue_ready), 64'd1);
    tick();
    flush = 1'b0;
    issue_valid = 1'b0;
    cdb_valid = 1'b0;
    rs1_tag = 3'd0;
    #1;
    chk("flush_commit_valid", 64'(commit_valid), 64'd0);
    chk("flush_issue_tag", 64'(issue_tag), 64'd0);
    chk("flush_rs1_ready", 64'(rs1_ready), 64'd0);

    // Four live entries, then asynchronous reset between clock edges.
    commit_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_issue(64'h600 + 64'(4 * i), RL'(i), 1'b0);
      #1;
      chk("post_flush_tag", 64'(issue_tag), 64'(i));
      tick();
    end
    issue_valid = 1'b0;
    #1;
    chk("four_live_ready", 64'(issue_ready), 64'd1);
    chk("four_live_tag", 64'(issue_tag), 64'd4);
    drive_cdb(3'd0, 64'h1, 1'b0);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("pre_reset_commit_valid", 64'(commit_valid), 64'd1);
    chk("pre_reset_rs1_ready", 64'(rs1_ready), 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("async_rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("async_rst_issue_tag", 64'(issue_tag), 64'd0);
    chk("async_rst_rs1_ready", 64'(rs1_ready), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
